// File: rtl/mrx_packet_ctrl.sv
// Receive packet sequencer: assembles 64-bit IO words into PW-bit packets for the rx FIFO.
// Optional accepted-packet counter enabled by defining MRX_PKT_COUNT_EN.
module mrx_packet_ctrl #(
  parameter int PW = 104
) (
  input  logic          rx_clk,
  input  logic          io_nreset,
  input  logic          io_access,
  input  logic [7:0]    io_valid,
  input  logic [63:0]   io_packet,
  input  logic          fifo_wait,
  input  logic          err_clear,
  output logic          fifo_access,
  output logic [PW-1:0] fifo_packet,
  output logic          rx_wait,
  output logic [7:0]    err_short,
  output logic [7:0]    err_ovf,
  output logic [31:0]   pkt_count
);

  localparam int NW = (PW + 63) / 64;
  localparam int LB = PW / 8 - 8 * (NW - 1);
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int BW = (NW > 1) ? NW - 1 : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0][63:0]  wbuf;
  logic [PW-1:0]        words;
  logic [3:0]           nbytes;
  logic                 last;
  logic                 advance;
  logic                 complete;
  logic                 abort_word;
  logic                 overflow;

  always_comb begin
    nbytes = '0;
    for (int unsigned i = 0; i < 8; i++)
      nbytes = nbytes + {3'b000, io_valid[i]};
  end

  // In IDLE the counter is zero, so the word is the last one only for single-word packets.
  always_comb begin
    last       = (state == COLLECT) ? (cnt == CW'(NW - 1)) : (NW == 1);
    advance    = io_access & ~last & (io_valid == 8'hFF);
    complete   = io_access & last & (nbytes >= 4'(LB));
    abort_word = io_access & ~advance & ~complete;
    overflow   = complete & fifo_access & fifo_wait;
  end

  generate
    if (NW > 1) begin : g_multi
      always_comb words = PW'({io_packet, wbuf});
    end else begin : g_single
      always_comb words = PW'(io_packet);
    end
  endgenerate

  always_ff @(posedge rx_clk or negedge io_nreset) begin
    if (!io_nreset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (advance) begin
      state <= COLLECT;
      cnt   <= cnt + 1'b1;
    end else if (complete || abort_word) begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge rx_clk) begin
    for (int unsigned i = 0; i < BW; i++)
      if (advance && (cnt == CW'(i)))
        wbuf[i] <= io_packet;
  end

  // A completion may load whenever the output is free or being accepted this cycle.
  always_ff @(posedge rx_clk or negedge io_nreset) begin
    if (!io_nreset) begin
      fifo_access <= 1'b0;
      fifo_packet <= '0;
      rx_wait     <= 1'b0;
    end else begin
      rx_wait <= fifo_wait | (fifo_access & fifo_wait);
      if (complete && (!fifo_access || !fifo_wait)) begin
        fifo_access <= 1'b1;
        fifo_packet <= words;
      end else if (fifo_access && !fifo_wait) begin
        fifo_access <= 1'b0;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge io_nreset) begin
    if (!io_nreset) begin
      err_short <= '0;
      err_ovf   <= '0;
    end else if (err_clear) begin
      err_short <= '0;
      err_ovf   <= '0;
    end else begin
      if (abort_word && (err_short != 8'hFF))
        err_short <= err_short + 8'd1;
      if (overflow && (err_ovf != 8'hFF))
        err_ovf <= err_ovf + 8'd1;
    end
  end

`ifdef MRX_PKT_COUNT_EN
  always_ff @(posedge rx_clk or negedge io_nreset) begin
    if (!io_nreset)
      pkt_count <= '0;
    else if (err_clear)
      pkt_count <= '0;
    else if (fifo_access && !fifo_wait)
      pkt_count <= pkt_count + 32'd1;
  end
`else
  assign pkt_count = '0;
`endif

endmodule
